// File: rtl/board_mem_arbiter.sv
// Game-board cell store (2 bits per cell) with one access port shared by the VGA renderer,
// the game-logic request/ack port and a full-board clear sequencer.
module board_mem_arbiter #(
   parameter int ROWS = 15,
   parameter int COLS = 15,
   parameter int RW   = 4,
   parameter int CW   = 4
) (
   input  logic          clk,
   input  logic          clrn,
   input  logic          vga_ce,
   input  logic [RW-1:0] vga_row,
   input  logic [CW-1:0] vga_col,
   output logic [1:0]    vga_state,
   input  logic          gl_req,
   input  logic          gl_we,
   input  logic [RW-1:0] gl_row,
   input  logic [CW-1:0] gl_col,
   input  logic [1:0]    gl_wdata,
   output logic          gl_ack,
   output logic [1:0]    gl_rdata,
   output logic          gl_err,
   input  logic          clr_req,
   output logic          busy
);

   localparam int CELLS = ROWS * COLS;
   localparam int IW    = $clog2(CELLS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACK,
      S_CLEAR
   } state_e;

   function automatic logic in_range(input logic [RW-1:0] row, input logic [CW-1:0] col);
      return (int'(row) < ROWS) && (int'(col) < COLS);
   endfunction

   function automatic logic [IW-1:0] cell_idx(input logic [RW-1:0] row, input logic [CW-1:0] col);
      return IW'(int'(row) * COLS + int'(col));
   endfunction

   state_e                  state_q, state_d;
   logic [CELLS-1:0][1:0]   cells_q, cells_d;
   logic [IW-1:0]           clr_cnt_q, clr_cnt_d;
   logic [1:0]              vga_state_q, vga_state_d;
   logic                    gl_ack_q, gl_ack_d;
   logic [1:0]              gl_rdata_q, gl_rdata_d;
   logic                    gl_err_q, gl_err_d;

   logic                    vga_ok, gl_ok;
   logic [IW-1:0]           vga_idx, gl_idx;
   logic [1:0]              gl_cur;

   assign vga_ok  = in_range(vga_row, vga_col);
   assign gl_ok   = in_range(gl_row, gl_col);
   assign vga_idx = cell_idx(vga_row, vga_col);
   assign gl_idx  = cell_idx(gl_row, gl_col);
   assign gl_cur  = gl_ok ? cells_q[gl_idx] : 2'b00;

   // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      cells_d     = cells_q;
      clr_cnt_d   = clr_cnt_q;
      vga_state_d = vga_state_q;
      gl_ack_d    = 1'b0;
      gl_err_d    = 1'b0;
      gl_rdata_d  = gl_rdata_q;

      // The renderer owns the port in vga_ce cycles; nothing else touches the store then.
      if (vga_ce) begin
         vga_state_d = vga_ok ? cells_q[vga_idx] : 2'b00;
      end

      case (state_q)
         S_IDLE: begin
            if (clr_req) begin
               state_d = S_CLEAR;
            end else if (gl_req && !vga_ce) begin
               state_d  = S_ACK;
               gl_ack_d = 1'b1;
               if (!gl_ok) begin
                  gl_rdata_d = 2'b00;
                  gl_err_d   = 1'b1;
               end else begin
                  gl_rdata_d = gl_cur;
                  // Placing a stone on an occupied cell is refused; writing 00 (undo) never is.
                  if (gl_we && gl_wdata != 2'b00 && gl_cur != 2'b00) begin
                     gl_err_d = 1'b1;
                  end else if (gl_we) begin
                     cells_d[gl_idx] = gl_wdata;
                  end
               end
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         S_CLEAR: begin
            if (!vga_ce) begin
               cells_d[clr_cnt_q] = 2'b00;
               if (clr_cnt_q == IW'(CELLS - 1)) begin
                  clr_cnt_d = '0;
                  state_d   = S_IDLE;
               end else begin
                  clr_cnt_d = clr_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk) begin
      if (!clrn) begin
         state_q     <= S_IDLE;
         // NOTE: the board itself is reset, since a restart must present an empty board.
         cells_q     <= '0;
         clr_cnt_q   <= '0;
         vga_state_q <= 2'b00;
         gl_ack_q    <= 1'b0;
         gl_rdata_q  <= 2'b00;
         gl_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cells_q     <= cells_d;
         clr_cnt_q   <= clr_cnt_d;
         vga_state_q <= vga_state_d;
         gl_ack_q    <= gl_ack_d;
         gl_rdata_q  <= gl_rdata_d;
         gl_err_q    <= gl_err_d;
      end
   end

   assign vga_state = vga_state_q;
   assign gl_ack    = gl_ack_q;
   assign gl_rdata  = gl_rdata_q;
   assign gl_err    = gl_err_q;
   assign busy      = (state_q == S_CLEAR);

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Bench for board_mem_arbiter: directed scenarios plus randomized traffic scored against
// a plain array model of the board and its access rules.
module tb_board_mem_arbiter;

   localparam int ROWS  = 15;
   localparam int COLS  = 15;
   localparam int CELLS = ROWS * COLS;

   logic       clk = 1'b0;
   logic       clrn;
   logic       vga_ce;
   logic [3:0] vga_row, vga_col;
   logic [1:0] vga_state;
   logic       gl_req, gl_we;
   logic [3:0] gl_row, gl_col;
   logic [1:0] gl_wdata;
   logic       gl_ack;
   logic [1:0] gl_rdata;
   logic       gl_err;
   logic       clr_req;
   logic       busy;

   int         err_cnt = 0;
   int         chk_cnt = 0;
   logic [1:0] ref_cells [CELLS];
   logic [1:0] exp_vga;

   board_mem_arbiter #(.ROWS(ROWS), .COLS(COLS), .RW(4), .CW(4)) dut (
      .clk(clk), .clrn(clrn),
      .vga_ce(vga_ce), .vga_row(vga_row), .vga_col(vga_col), .vga_state(vga_state),
      .gl_req(gl_req), .gl_we(gl_we), .gl_row(gl_row), .gl_col(gl_col), .gl_wdata(gl_wdata),
      .gl_ack(gl_ack), .gl_rdata(gl_rdata), .gl_err(gl_err),
      .clr_req(clr_req), .busy(busy)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] ref_cell(input logic [3:0] r, input logic [3:0] c);
      if (int'(r) >= ROWS || int'(c) >= COLS) return 2'b00;
      return ref_cells[int'(r) * COLS + int'(c)];
   endfunction

   // Board access rules: report prior contents, refuse out-of-range and overwrite of a stone.
   task automatic ref_access(input logic we, input logic [3:0] r, input logic [3:0] c,
                             input logic [1:0] wd, output logic [1:0] er, output logic ee);
      if (int'(r) >= ROWS || int'(c) >= COLS) begin
         er = 2'b00;
         ee = 1'b1;
      end else begin
         er = ref_cells[int'(r) * COLS + int'(c)];
         if (we && wd != 2'b00 && er != 2'b00) ee = 1'b1;
         else begin
            ee = 1'b0;
            if (we) ref_cells[int'(r) * COLS + int'(c)] = wd;
         end
      end
   endtask

   task automatic ref_clear();
      for (int i = 0; i < CELLS; i++) ref_cells[i] = 2'b00;
   endtask

   task automatic do_access(input logic we, input logic [3:0] r, input logic [3:0] c,
                            input logic [1:0] wd);
      logic [1:0] er;
      logic       ee;
      int         waited;
      gl_req = 1'b1; gl_we = we; gl_row = r; gl_col = c; gl_wdata = wd; vga_ce = 1'b0;
      tick();
      waited = 1;
      while (!gl_ack && waited < 8) begin
         tick();
         waited++;
      end
      check("acc_latency", 32'(waited), 32'd1);
      ref_access(we, r, c, wd, er, ee);
      check("acc_rdata", 32'(gl_rdata), 32'(er));
      check("acc_err", 32'(gl_err), 32'(ee));
      gl_req = 1'b0;
      tick();
      check("acc_ack_pulse", 32'(gl_ack), 32'd0);
      check("acc_err_idle", 32'(gl_err), 32'd0);
   endtask

   task automatic vga_probe(input logic [3:0] r, input logic [3:0] c);
      vga_ce = 1'b1; vga_row = r; vga_col = c;
      exp_vga = ref_cell(r, c);
      tick();
      vga_ce = 1'b0; vga_row = 4'd0; vga_col = 4'd0;
      check("vga_state", 32'(vga_state), 32'(exp_vga));
      tick();
      check("vga_hold", 32'(vga_state), 32'(exp_vga));
   endtask

   task automatic read_board(input string tag);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            do_access(1'b0, 4'(r), 4'(c), 2'b00);
      check(tag, 32'(gl_ack), 32'd0);
   endtask

   // Clear with vga_ce every 4th clock; optionally reset part-way through.
   task automatic run_clear(input int reset_at);
      int zeros, exp_n, busy_n, ack_seen;
      zeros = 0; exp_n = -1; busy_n = 0; ack_seen = 0;
      gl_req = 1'b1; gl_we = 1'b1; gl_row = 4'd5; gl_col = 4'd5; gl_wdata = 2'b10;
      clr_req = 1'b1; vga_ce = 1'b0;
      tick();
      clr_req = 1'b0;
      check("clr_busy_start", 32'(busy), 32'd1);
      busy_n = 1;
      for (int k = 1; k < 1000; k++) begin
         vga_ce  = (k % 4 == 1);
         if (!vga_ce) zeros++;
         if (zeros == CELLS && exp_n < 0) exp_n = k;
         gl_req  = (k < 50);
         clr_req = (k == 100);
         if (k == reset_at) clrn = 1'b0;
         tick();
         clrn    = 1'b1;
         clr_req = 1'b0;
         if (gl_ack) ack_seen++;
         if (k == reset_at) begin
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_ack", 32'(gl_ack), 32'd0);
            check("rst_vga", 32'(vga_state), 32'd0);
            break;
         end
         if (!busy) break;
         busy_n++;
      end
      gl_req = 1'b0; vga_ce = 1'b0;
      if (reset_at < 0) check("clr_busy_cycles", 32'(busy_n), 32'(exp_n));
      check("clr_ack_ignored", 32'(ack_seen), 32'd0);
      ref_clear();
      exp_vga = 2'b00;
      tick();
   endtask

   initial begin
      logic       pend;
      int         age;
      logic [1:0] er;
      logic       ee;

      clrn = 1'b0; vga_ce = 1'b0; vga_row = '0; vga_col = '0;
      gl_req = 1'b0; gl_we = 1'b0; gl_row = '0; gl_col = '0; gl_wdata = '0; clr_req = 1'b0;
      ref_clear();
      exp_vga = 2'b00;
      tick();
      tick();
      check("rst_vga_state", 32'(vga_state), 32'd0);
      check("rst_gl_ack", 32'(gl_ack), 32'd0);
      check("rst_gl_rdata", 32'(gl_rdata), 32'd0);
      check("rst_gl_err", 32'(gl_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      clrn = 1'b1;
      tick();

      read_board("board_after_reset");

      do_access(1'b1, 4'd3, 4'd4, 2'b01);
      vga_probe(4'd3, 4'd4);
      do_access(1'b1, 4'd3, 4'd4, 2'b10);
      vga_probe(4'd3, 4'd4);
      do_access(1'b1, 4'd3, 4'd4, 2'b00);
      vga_probe(4'd3, 4'd4);

      // Request raised in a renderer slot is stalled one cycle.
      gl_req = 1'b1; gl_we = 1'b0; gl_row = 4'd3; gl_col = 4'd4; vga_ce = 1'b1;
      vga_row = 4'd0; vga_col = 4'd0;
      exp_vga = ref_cell(4'd0, 4'd0);
      tick();
      check("stall_no_ack", 32'(gl_ack), 32'd0);
      vga_ce = 1'b0;
      tick();
      check("stall_ack", 32'(gl_ack), 32'd1);
      ref_access(1'b0, 4'd3, 4'd4, 2'b00, er, ee);
      check("stall_rdata", 32'(gl_rdata), 32'(er));
      gl_req = 1'b0;
      tick();
      check("stall_ack_drop", 32'(gl_ack), 32'd0);

      do_access(1'b1, 4'd15, 4'd0, 2'b01);
      do_access(1'b1, 4'd0, 4'd15, 2'b10);
      do_access(1'b0, 4'd15, 4'd15, 2'b00);
      vga_probe(4'd15, 4'd2);

      // Randomized traffic, requests held until acked (back-to-back allowed).
      pend = 1'b0;
      age  = 0;
      for (int cyc = 0; cyc < 1200; cyc++) begin
         if (cyc >= 800 && !pend) break;
         if (!pend && cyc < 800 && $urandom_range(1, 0) == 1) begin
            pend     = 1'b1;
            age      = 0;
            gl_we    = 1'($urandom_range(3, 0) != 0);
            gl_row   = 4'($urandom_range(15, 0));
            gl_col   = 4'($urandom_range(15, 0));
            gl_wdata = 2'($urandom_range(3, 0));
         end
         gl_req  = pend;
         vga_ce  = ($urandom_range(2, 0) == 0);
         vga_row = 4'($urandom_range(15, 0));
         vga_col = 4'($urandom_range(15, 0));
         if (vga_ce) exp_vga = ref_cell(vga_row, vga_col);
         tick();
         check("rnd_vga", 32'(vga_state), 32'(exp_vga));
         if (gl_ack) begin
            check("rnd_ack_pending", 32'(pend), 32'd1);
            if (pend) begin
               ref_access(gl_we, gl_row, gl_col, gl_wdata, er, ee);
               check("rnd_rdata", 32'(gl_rdata), 32'(er));
               check("rnd_err", 32'(gl_err), 32'(ee));
               pend = 1'b0;
            end
         end else begin
            check("rnd_err_idle", 32'(gl_err), 32'd0);
            if (pend) begin
               age++;
               if (age > 16) begin
                  check("rnd_req_timeout", 32'(gl_ack), 32'd1);
                  pend = 1'b0;
               end
            end
         end
      end
      gl_req = 1'b0; vga_ce = 1'b0;
      tick();
      read_board("board_after_random");

      do_access(1'b1, 4'd0, 4'd0, 2'b01);
      do_access(1'b1, 4'd7, 4'd7, 2'b10);
      do_access(1'b1, 4'd14, 4'd14, 2'b11);
      run_clear(-1);
      read_board("board_after_clear");

      do_access(1'b1, 4'd1, 4'd2, 2'b01);
      do_access(1'b1, 4'd9, 4'd9, 2'b10);
      run_clear(60);
      read_board("board_after_mid_clear_reset");

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
